// File: rtl/alu_pkg.sv
// Shared ALU opcodes and widths for the execute stage and the control decoder.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;
    localparam logic [3:0] ALU_LUI  = 4'd12;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_mode_e;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode bundle into the ALU and its registered result/zero flag.
interface alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] a2;
    logic [3:0]       alu_ctrl;
    logic             zero;
    logic [WIDTH-1:0] alu_out;

    modport master (
        output a1, a2, alu_ctrl,
        input  zero, alu_out
    );

    modport slave (
        input  a1, a2, alu_ctrl,
        output zero, alu_out
    );
endinterface

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: logical left/right and arithmetic right.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [SHW-1:0]   shamt_i,
    input  shift_mode_e      mode_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = a_i << shamt_i;
        case (mode_i)
            SH_SRL:  y_o = a_i >> shamt_i;
            SH_SRA:  y_o = $unsigned($signed(a_i) >>> shamt_i);
            default: y_o = a_i << shamt_i;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: opcode mux over a shared adder and shifter,
// with the result and its zero flag registered together.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input logic   clk,
    input logic   rst_n,
    alu_if.slave  bus
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] a1_i;
    logic [WIDTH-1:0] a2_i;
    logic [3:0]       ctrl_i;
    logic             sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic             lt_s;
    logic             lt_u;
    shift_mode_e      sh_mode;
    logic [WIDTH-1:0] sh_y;
    logic [WIDTH-1:0] alu_out_d;
    logic [WIDTH-1:0] alu_out_q;
    logic             zero_d;
    logic             zero_q;

    assign a1_i   = bus.a1;
    assign a2_i   = bus.a2;
    assign ctrl_i = bus.alu_ctrl;

    // SLT/SLTU reuse the subtractor: a1 + ~a2 + 1
    assign sub  = (ctrl_i == ALU_SUB) || (ctrl_i == ALU_SLT)
               || (ctrl_i == ALU_SLTU);
    assign b_op = sub ? ~a2_i : a2_i;
    assign sum  = {1'b0, a1_i} + {1'b0, b_op}
                + {{WIDTH{1'b0}}, sub};

    // Differing signs decide directly, so overflow cannot flip the result
    assign lt_s = (a1_i[WIDTH-1] ^ a2_i[WIDTH-1]) ? a1_i[WIDTH-1]
                                                  : sum[WIDTH-1];
    assign lt_u = ~sum[WIDTH];

    always_comb begin
        sh_mode = SH_SLL;
        if (ctrl_i == ALU_SRL) sh_mode = SH_SRL;
        if (ctrl_i == ALU_SRA) sh_mode = SH_SRA;
    end

    alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .a_i     (a2_i),
        .shamt_i (a1_i[SHW-1:0]),
        .mode_i  (sh_mode),
        .y_o     (sh_y)
    );

    always_comb begin
        alu_out_d = '0;
        case (ctrl_i)
            ALU_ADD:  alu_out_d = sum[WIDTH-1:0];
            ALU_SUB:  alu_out_d = sum[WIDTH-1:0];
            ALU_AND:  alu_out_d = a1_i & a2_i;
            ALU_OR:   alu_out_d = a1_i | a2_i;
            ALU_NOR:  alu_out_d = ~(a1_i | a2_i);
            ALU_SLT:  alu_out_d = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_XOR:  alu_out_d = a1_i ^ a2_i;
            ALU_SLTU: alu_out_d = {{(WIDTH-1){1'b0}}, lt_u};
            ALU_SLL:  alu_out_d = sh_y;
            ALU_SRL:  alu_out_d = sh_y;
            ALU_SRA:  alu_out_d = sh_y;
            ALU_LUI:  alu_out_d = WIDTH'(a2_i[15:0]) << 16;
            default:  alu_out_d = '0;
        endcase
    end

    assign zero_d = (alu_out_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_q <= '0;
            zero_q    <= 1'b1;
        end else begin
            alu_out_q <= alu_out_d;
            zero_q    <= zero_d;
        end
    end

    assign bus.alu_out = alu_out_q;
    assign bus.zero    = zero_q;

endmodule

// File: tb/tb_alu.sv
// Directed vector table, reset corner cases and random ops against
// an arithmetic reference model of the ALU.
module tb_alu;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    alu_if bus_if ();

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a1;
        logic [31:0] a2;
        logic [3:0]  ctrl;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0]  op);
        int unsigned sh;
        sh = a % 32;
        case (op)
            4'd1:  return a + b;
            4'd2:  return a - b;
            4'd3:  return a & b;
            4'd4:  return a | b;
            4'd5:  return ~(a | b);
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return a ^ b;
            4'd8:  return (a < b) ? 32'd1 : 32'd0;
            4'd9:  return b << sh;
            4'd10: return b >> sh;
            4'd11: return $unsigned($signed(b) >>> sh);
            4'd12: return b * 32'h10000;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [31:0] exp);
        check(name, bus_if.alu_out, exp);
        check({name, " zero"}, {31'd0, bus_if.zero},
              (exp == 32'd0) ? 32'd1 : 32'd0);
    endtask

    task automatic drive(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [3:0]  op);
        @(negedge clk);
        bus_if.a1       = a;
        bus_if.a2       = b;
        bus_if.alu_ctrl = op;
    endtask

    task automatic run(input string name,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [3:0]  op,
                       input logic [31:0] exp);
        drive(a, b, op);
        @(posedge clk);
        #1;
        check_out(name, exp);
    endtask

    initial begin
        tbl.push_back('{32'd10, 32'd1, ALU_ADD, 32'd11});
        tbl.push_back('{32'd10, 32'd1, ALU_SUB, 32'd9});
        tbl.push_back('{32'd10, 32'd1, ALU_AND, 32'd0});
        tbl.push_back('{32'd10, 32'd1, ALU_OR,  32'd11});
        tbl.push_back('{32'd10, 32'd1, ALU_NOR, 32'hFFFFFFF4});
        tbl.push_back('{32'd10, 32'd1, ALU_SLT, 32'd0});
        tbl.push_back('{32'd10, 32'd1, ALU_XOR, 32'd11});
        tbl.push_back('{32'd1,  32'd10, ALU_SLT, 32'd1});
        tbl.push_back('{32'hFFFFFFFF, 32'd1, ALU_SLT,  32'd1});
        tbl.push_back('{32'hFFFFFFFF, 32'd1, ALU_SLTU, 32'd0});
        tbl.push_back('{32'd1, 32'hFFFFFFFF, ALU_SLTU, 32'd1});
        tbl.push_back('{32'h80000000, 32'h7FFFFFFF, ALU_SLT, 32'd1});
        tbl.push_back('{32'h7FFFFFFF, 32'h80000000, ALU_SLT, 32'd0});
        tbl.push_back('{32'hFFFFFFFF, 32'd1, ALU_ADD, 32'd0});
        tbl.push_back('{32'd0, 32'd1, ALU_SUB, 32'hFFFFFFFF});
        tbl.push_back('{32'd5, 32'd5, ALU_SUB, 32'd0});
        tbl.push_back('{32'd4, 32'h80000000, ALU_SRL, 32'h08000000});
        tbl.push_back('{32'd4, 32'h80000000, ALU_SRA, 32'hF8000000});
        tbl.push_back('{32'd4, 32'h80000000, ALU_SLL, 32'd0});
        tbl.push_back('{32'd0, 32'hDEADBEEF, ALU_SLL, 32'hDEADBEEF});
        tbl.push_back('{32'd0, 32'hDEADBEEF, ALU_SRA, 32'hDEADBEEF});
        tbl.push_back('{32'd31, 32'd1, ALU_SLL, 32'h80000000});
        tbl.push_back('{32'd31, 32'h80000000, ALU_SRA, 32'hFFFFFFFF});
        tbl.push_back('{32'd31, 32'h80000000, ALU_SRL, 32'd1});
        tbl.push_back('{32'h24, 32'h10, ALU_SLL, 32'h100});
        tbl.push_back('{32'd0, 32'h1234, ALU_LUI, 32'h12340000});
        tbl.push_back('{32'd0, 32'hABCD1234, ALU_LUI, 32'h12340000});
        tbl.push_back('{32'hF, 32'hF0, ALU_NOP, 32'd0});
        tbl.push_back('{32'hF, 32'hF0, 4'd13, 32'd0});
        tbl.push_back('{32'hF, 32'hF0, 4'd14, 32'd0});
        tbl.push_back('{32'hF, 32'hF0, 4'd15, 32'd0});

        bus_if.a1       = 32'd0;
        bus_if.a2       = 32'd0;
        bus_if.alu_ctrl = ALU_NOP;

        // Held in reset: inputs toggle, outputs stay cleared
        for (int i = 0; i < 4; i++) begin
            drive($urandom, $urandom, ALU_ADD);
            @(posedge clk);
            #1;
            check_out("hold reset", 32'd0);
        end

        drive(32'd10, 32'd1, ALU_ADD);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("first capture", 32'd11);

        for (int i = 0; i < tbl.size(); i++)
            run($sformatf("vec%0d op%0d", i, tbl[i].ctrl),
                tbl[i].a1, tbl[i].a2, tbl[i].ctrl, tbl[i].exp);

        // Asynchronous reset between edges
        run("pre reset", 32'd10, 32'd1, ALU_ADD, 32'd11);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async reset", 32'd0);
        @(posedge clk);
        #1;
        check_out("reset edge", 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("post reset", 32'd7, 32'd3, ALU_SUB, 32'd4);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [3:0]  op;
            a  = $urandom;
            b  = $urandom;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) b = a;
            if ($urandom_range(0, 3) == 0) a = a & 32'h3F;
            run($sformatf("rand%0d op%0d", i, op), a, b, op,
                model(a, b, op));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
